// File: rtl/seg_pkg.sv
// Shared definitions for the 7-segment scan path.
//   DIGIT_W   : width of one hex digit code
//   SEG_BLANK : nibble code that hex_display users treat as "segments off"
//   an_level  : maps a logical "digit on" bit to the pin level for a given polarity
package seg_pkg;

  localparam int unsigned DIGIT_W = 4;

  localparam logic [DIGIT_W-1:0] SEG_BLANK = 4'hF;

  function automatic logic an_level(input logic on, input logic active_low);
    return on ^ active_low;
  endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// Refresh prescaler: counts 0..REFRESH_DIV-1 and flags the last count.
//   clk  : system clock
//   rst  : synchronous active-high reset
//   tick : high combinationally while the count is REFRESH_DIV-1
module scan_tick_gen #(
  parameter int unsigned REFRESH_DIV = 50000
) (
  input  logic clk,
  input  logic rst,
  output logic tick
);

  localparam int unsigned CntW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(REFRESH_DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign tick = (cnt_q == LastCnt);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (tick) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/seg_scan_mux.sv
// Time-multiplexed scanner for an N-digit 7-segment display.
// Keeps a frame-coherent copy of the displayed value: loads land in a pending
// buffer and are promoted only at the frame wrap, so a frame never mixes values.
//   clk, rst    : system clock, synchronous active-high reset
//   value_in    : DIGITS hex nibbles, digit 0 rightmost
//   dp_in       : decimal-point request per digit
//   digit_mask  : live per-digit enable
//   load        : one-cycle capture strobe for value_in/dp_in
//   nibble, dp  : registered code and decimal point of the current digit
//   an          : registered one-hot digit enable (inverted if AN_ACTIVE_LOW)
//   frame_tick  : one-cycle pulse after the scan wraps to digit 0
// Optional build macro SEG_SCAN_LZB_EN enables leading-zero blanking.
module seg_scan_mux
  import seg_pkg::*;
#(
  parameter int unsigned DIGITS        = 4,
  parameter int unsigned REFRESH_DIV   = 50000,
  parameter bit          AN_ACTIVE_LOW = 1'b0
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [DIGIT_W*DIGITS-1:0] value_in,
  input  logic [DIGITS-1:0]         dp_in,
  input  logic [DIGITS-1:0]         digit_mask,
  input  logic                      load,
  output logic [DIGIT_W-1:0]        nibble,
  output logic                      dp,
  output logic [DIGITS-1:0]         an,
  output logic                      frame_tick
);

  localparam int unsigned IdxW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(DIGITS - 1);

  logic tick, wrap;

  logic [IdxW-1:0]                 idx_q, idx_d;
  logic [DIGITS-1:0][DIGIT_W-1:0]  act_q, act_d, pend_q, pend_d;
  logic [DIGITS-1:0]               act_dp_q, act_dp_d, pend_dp_q, pend_dp_d;
  logic                            pend_valid_q, pend_valid_d;

  logic [DIGITS-1:0]  blank, sel, an_on, an_d;
  logic [DIGIT_W-1:0] nibble_q, nibble_d;
  logic               dp_q, dp_d;
  logic [DIGITS-1:0]  an_q;
  logic               frame_tick_q;

  scan_tick_gen #(
    .REFRESH_DIV(REFRESH_DIV)
  ) u_tick (
    .clk (clk),
    .rst (rst),
    .tick(tick)
  );

  assign wrap = tick && (idx_q == LastIdx);

`ifdef SEG_SCAN_LZB_EN
  // Scan down from the top digit; blanking stops at the first digit that is
  // nonzero or carries a decimal point. Digit 0 always shows.
  always_comb begin
    logic zero_run;
    blank    = '0;
    zero_run = 1'b1;
    for (int k = DIGITS - 1; k >= 1; k--) begin
      zero_run = zero_run & (act_q[k] == '0) & ~act_dp_q[k];
      blank[k] = zero_run;
    end
  end
`else
  assign blank = '0;
`endif

  always_comb begin
    idx_d = idx_q;
    if (tick) idx_d = (idx_q == LastIdx) ? '0 : idx_q + 1'b1;

    act_d        = act_q;
    act_dp_d     = act_dp_q;
    pend_d       = pend_q;
    pend_dp_d    = pend_dp_q;
    pend_valid_d = pend_valid_q;

    if (wrap) begin
      // A load on the wrap cycle bypasses the pending buffer.
      if (load) begin
        act_d    = value_in;
        act_dp_d = dp_in;
      end else if (pend_valid_q) begin
        act_d    = pend_q;
        act_dp_d = pend_dp_q;
      end
      pend_valid_d = 1'b0;
    end else if (load) begin
      pend_d       = value_in;
      pend_dp_d    = dp_in;
      pend_valid_d = 1'b1;
    end
  end

  always_comb begin
    sel      = DIGITS'(1) << idx_q;
    // Tick cycle is a dead slot with every digit off to avoid ghosting.
    an_on    = tick ? '0 : (sel & digit_mask & ~blank);
    nibble_d = act_q[idx_q];
    dp_d     = act_dp_q[idx_q];
    an_d     = '0;
    for (int k = 0; k < DIGITS; k++) begin
      an_d[k] = an_level(an_on[k], AN_ACTIVE_LOW);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_q        <= '0;
      act_q        <= '0;
      act_dp_q     <= '0;
      pend_q       <= '0;
      pend_dp_q    <= '0;
      pend_valid_q <= 1'b0;
      nibble_q     <= '0;
      dp_q         <= 1'b0;
      an_q         <= {DIGITS{an_level(1'b0, AN_ACTIVE_LOW)}};
      frame_tick_q <= 1'b0;
    end else begin
      idx_q        <= idx_d;
      act_q        <= act_d;
      act_dp_q     <= act_dp_d;
      pend_q       <= pend_d;
      pend_dp_q    <= pend_dp_d;
      pend_valid_q <= pend_valid_d;
      nibble_q     <= nibble_d;
      dp_q         <= dp_d;
      an_q         <= an_d;
      frame_tick_q <= wrap;
    end
  end

  assign nibble     = nibble_q;
  assign dp         = dp_q;
  assign an         = an_q;
  assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_seg_scan_mux.sv
// Self-checking bench for seg_scan_mux (DIGITS=4, REFRESH_DIV=4).
module tb_seg_scan_mux;

  localparam int unsigned D  = 4;
  localparam int unsigned R  = 4;
  localparam int unsigned FR = D * R;
  localparam bit          AL = 1'b0;
`ifdef SEG_SCAN_LZB_EN
  localparam bit LZB = 1'b1;
`else
  localparam bit LZB = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           rst;
  logic           load;
  logic [4*D-1:0] value_in;
  logic [D-1:0]   dp_in;
  logic [D-1:0]   digit_mask;
  logic [3:0]     nibble;
  logic           dp;
  logic [D-1:0]   an;
  logic           frame_tick;

  seg_scan_mux #(
    .DIGITS       (D),
    .REFRESH_DIV  (R),
    .AN_ACTIVE_LOW(AL)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .value_in  (value_in),
    .dp_in     (dp_in),
    .digit_mask(digit_mask),
    .load      (load),
    .nibble    (nibble),
    .dp        (dp),
    .an        (an),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]   nib;
    logic         dp;
    logic [D-1:0] an;
    logic         ft;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Model state: n = edges since reset release; m_* = displayed and pending copies.
  int           n;
  logic [4*D-1:0] m_val, m_pval;
  logic [D-1:0]   m_dp, m_pdp;
  bit             m_pv;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, n);
    end
  endtask

  // Digits above the highest significant one (nonzero or with dp) are blanked.
  function automatic logic [D-1:0] model_blank(input logic [4*D-1:0] v, input logic [D-1:0] d);
    int           top = 0;
    logic [D-1:0] b   = '0;
    for (int j = 0; j < D; j++) if (v[4*j +: 4] != 4'h0 || d[j]) top = j;
    for (int j = 1; j < D; j++) b[j] = LZB && (j > top);
    return b;
  endfunction

  task automatic step();
    exp_t         e;
    int           cnt;
    int           idx;
    logic [D-1:0] on;
    if (rst) begin
      e.nib = 4'h0;
      e.dp  = 1'b0;
      e.an  = {D{AL}};
      e.ft  = 1'b0;
    end else begin
      cnt   = n % R;
      idx   = (n / R) % D;
      on    = (cnt == R - 1) ? '0 : ((D'(1) << idx) & digit_mask & ~model_blank(m_val, m_dp));
      e.an  = on ^ {D{AL}};
      e.nib = m_val[4*idx +: 4];
      e.dp  = m_dp[idx];
      e.ft  = (n % FR == FR - 1);
    end
    sb.push_back(e);

    if (rst) begin
      n = 0; m_val = '0; m_dp = '0; m_pval = '0; m_pdp = '0; m_pv = 1'b0;
    end else begin
      if (n % FR == FR - 1) begin
        if (load) begin
          m_val = value_in; m_dp = dp_in;
        end else if (m_pv) begin
          m_val = m_pval; m_dp = m_pdp;
        end
        m_pv = 1'b0;
      end else if (load) begin
        m_pval = value_in; m_pdp = dp_in; m_pv = 1'b1;
      end
      n++;
    end

    @(posedge clk);
    #1;
    load = 1'b0;
    if (sb.size() == 0) begin
      check_eq("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      check_eq("nibble", nibble, e.nib);
      check_eq("dp", dp, e.dp);
      check_eq("an", an, e.an);
      check_eq("frame_tick", frame_tick, e.ft);
    end
  endtask

  task automatic run(input int k);
    repeat (k) step();
  endtask

  task automatic wait_phase(input int ph);
    while (n % FR != ph) step();
  endtask

  task automatic do_load(input logic [4*D-1:0] v, input logic [D-1:0] d);
    value_in = v;
    dp_in    = d;
    load     = 1'b1;
    step();
  endtask

  initial begin
    rst        = 1'b1;
    load       = 1'b0;
    value_in   = '0;
    dp_in      = '0;
    digit_mask = '1;
    n          = 0;
    m_val = '0; m_dp = '0; m_pval = '0; m_pdp = '0; m_pv = 1'b0;

    run(3);
    rst = 1'b0;
    run(40);                         // plain scan of zeros

    wait_phase(5);
    do_load(16'h1A3F, 4'b0000);      // mid-frame load, visible after wrap
    run(40);

    wait_phase(2);
    do_load(16'h1234, 4'b0000);
    run(3);
    do_load(16'h5678, 4'b0000);      // last load in the frame wins
    run(40);

    wait_phase(FR - 1);
    do_load(16'hBEEF, 4'b0010);      // load exactly on the wrap cycle
    run(40);

    do_load(16'hFFFF, 4'b0000);
    run(40);
    digit_mask = 4'b0101;
    run(40);
    digit_mask = 4'b1111;

    do_load(16'h0050, 4'b0000);
    run(40);
    do_load(16'h0000, 4'b0000);
    run(40);
    do_load(16'h0050, 4'b1000);
    run(40);

    wait_phase(6);
    do_load(16'h9999, 4'b1111);      // pending load discarded by reset
    run(2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    run(40);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
